// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES registered
// ripple segments, with valid/ready flow control and carry/overflow reporting.
module pipelined_rca_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    // Result packing: {carry out of segment, carry into segment MSB, segment sum}
    function automatic logic [SEG+1:0] rca_seg(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           c_in
    );
        logic [SEG:0]   c;
        logic [SEG-1:0] s;
        c[0] = c_in;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (b[i] & c[i]) | (a[i] & c[i]);
        end
        return {c[SEG], c[SEG-1], s};
    endfunction

    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] c_r;
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH-1:0]  s_r [STAGES];
    logic              ovf_r;

    logic [STAGES-1:0] v_in_s;
    logic [STAGES-1:0] c_in_s;
    logic [WIDTH-1:0]  a_in_s  [STAGES];
    logic [WIDTH-1:0]  b_in_s  [STAGES];
    logic [WIDTH-1:0]  s_in_s  [STAGES];
    logic [WIDTH-1:0]  s_nxt_s [STAGES];
    logic [SEG+1:0]    res_s   [STAGES];
    logic              stall_s;

    assign stall_s   = v_r[STAGES-1] & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = v_r[STAGES-1];
    assign sum       = s_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    assign ovf       = ovf_r;

    // Stage inputs and per-segment ripple; y is inverted at entry for subtraction
    always_comb begin
        v_in_s[0] = in_valid;
        a_in_s[0] = x;
        b_in_s[0] = sub ? ~y : y;
        c_in_s[0] = sub ? 1'b1 : cin;
        s_in_s[0] = {WIDTH{1'b0}};
        for (int k = 1; k < STAGES; k++) begin
            v_in_s[k] = v_r[k-1];
            a_in_s[k] = a_r[k-1];
            b_in_s[k] = b_r[k-1];
            c_in_s[k] = c_r[k-1];
            s_in_s[k] = s_r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            res_s[k]   = rca_seg(a_in_s[k][k*SEG +: SEG], b_in_s[k][k*SEG +: SEG], c_in_s[k]);
            s_nxt_s[k] = s_in_s[k];
            s_nxt_s[k][k*SEG +: SEG] = res_s[k][SEG-1:0];
        end
    end

    // Pipeline registers: whole pipe holds on stall, otherwise shifts one slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r   <= {STAGES{1'b0}};
            c_r   <= {STAGES{1'b0}};
            ovf_r <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= {WIDTH{1'b0}};
                b_r[k] <= {WIDTH{1'b0}};
                s_r[k] <= {WIDTH{1'b0}};
            end
        end else if (!stall_s) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= v_in_s[k];
                c_r[k] <= res_s[k][SEG+1];
                a_r[k] <= a_in_s[k];
                b_r[k] <= b_in_s[k];
                s_r[k] <= s_nxt_s[k];
            end
            ovf_r <= res_s[STAGES-1][SEG] ^ res_s[STAGES-1][SEG+1];
        end else begin
            ovf_r <= ovf_r;
        end
    end

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Self-checking bench for pipelined_rca_addsub: arithmetic reference model with an
// in-order expected queue, plus directed vectors with hand-computed results.
module tb_pipelined_rca_addsub;

    localparam int W  = 16;
    localparam int ST = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W+1:0] exp_q [$];

    pipelined_rca_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic, signed overflow from the true signed result
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic s);
        logic [W:0] u;
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        if (s) begin
            u = {1'b0, a} + {1'b0, ~b} + 17'd1;
            r = sa - sb;
        end else begin
            u = {1'b0, a} + {1'b0, b} + {16'd0, ci};
            r = sa + sb + (ci ? 1 : 0);
        end
        return {u[W-1:0], u[W], (r > 32767 || r < -32768)};
    endfunction

    // Compare process: scoreboard on every meaningful cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {14'd0, sum, cout, ovf}, 32'hDEAD);
                end else begin
                    check("result_vs_model", {14'd0, sum, cout, ovf}, {14'd0, exp_q[0]});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(x, y, cin, sub));
        end
    end

    task automatic run_op(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic acin,
                          input logic asub, input logic [W-1:0] esum, input logic ecout,
                          input logic eovf, input string nm);
        int  lat;
        bit  got;
        x = ax; y = ay; cin = acin; sub = asub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (out_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        check({nm, "_latency"}, got ? lat : 32'hFFFF, ST);
        check({nm, "_result"}, {14'd0, sum, cout, ovf}, {14'd0, esum, ecout, eovf});
        @(posedge clk); #1;
    endtask

    initial begin
        int sent, acc, cyc;
        bit now_ok;
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1;
        check("async_reset_sum", {16'd0, sum}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            check("idle_state", {13'd0, out_valid, in_ready, sum, cout, ovf},
                  {13'd0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0});
            @(posedge clk); #1;
        end

        // 2/3: directed vectors, literal expectations
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "add_00ff_1");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ffff_1");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_8000_1");
        run_op(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_3_5");
        run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, "add_cin_ovf");
        run_op(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_ignores_cin");

        // 4: random stream with random back-pressure
        sent = 0; cyc = 0; now_ok = 1'b1;
        while (sent < 100 && cyc < 5000) begin
            if (now_ok) begin
                x = W'($urandom); y = W'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
            in_valid  = 1'b1;
            out_ready = ($urandom_range(0, 9) >= 3);
            #1;
            now_ok = in_ready;
            @(posedge clk); #1;
            if (now_ok) sent++;
            cyc++;
        end
        check("stream_sent", sent, 100);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("stream_drained", exp_q.size(), 0);

        // 6: full stall holds exactly STAGES ops
        acc = 0; out_ready = 1'b0; now_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (now_ok) begin
                x = W'($urandom); y = W'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
            in_valid = 1'b1;
            #1;
            now_ok = in_ready;
            @(posedge clk); #1;
            if (now_ok) acc++;
        end
        check("stall_accepted", acc, ST);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("stall_drained", exp_q.size(), 0);
        check("stall_idle_after", {31'd0, out_valid}, 32'd0);

        // 5: reset mid-flight discards three in-flight ops
        for (int i = 0; i < 3; i++) begin
            x = W'($urandom); y = W'($urandom); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midflight_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midflight_reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check("after_reset_nothing", {31'd0, out_valid}, 32'd0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "post_reset_add");

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
